// File: rtl/lsd_readout_ctrl.sv
// Readout sequencer for the LSD line-segment buffer: protects the buffer, streams
// its valid words over a valid/ready interface with a last flag, then releases it.
module lsd_readout_ctrl #(
  parameter int FRAME_HEIGHT = 525,
  parameter int FRAME_WIDTH  = 800,
  parameter int RAM_SIZE     = 4096,
  parameter int TIMEOUT_CYC  = 1048576,
  localparam int V_BITW      = $clog2(FRAME_HEIGHT),
  localparam int H_BITW      = $clog2(FRAME_WIDTH),
  localparam int ADDR_BITW   = $clog2(RAM_SIZE),
  localparam int WORD_SIZE   = 2 * (H_BITW + V_BITW)
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic                 in_start,
  input  logic                 in_buf_ready,
  input  logic [ADDR_BITW:0]   in_buf_line_num,
  input  logic [WORD_SIZE-1:0] in_buf_data,
  output logic                 out_write_protect,
  output logic [ADDR_BITW-1:0] out_rd_addr,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_last,
  input  logic                 in_ready,
  output logic                 out_busy,
  output logic                 out_done,
  output logic                 out_timeout,
  output logic [ADDR_BITW:0]   out_seg_count
);

  localparam int TIMER_BITW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TIMER_BITW-1:0] TIMER_LAST = TIMER_BITW'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_BITW:0]    ONE_WORD   = (ADDR_BITW + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    PROTECT,
    LOAD,
    STREAM,
    RELEASE
  } state_t;

  state_t                 r_state;
  logic [TIMER_BITW-1:0]  r_timer;
  logic [ADDR_BITW:0]     r_lineNum;
  logic [ADDR_BITW-1:0]   r_rdAddr;
  logic [ADDR_BITW:0]     r_cnt;
  logic                   r_protect;
  logic                   r_valid;
  logic [WORD_SIZE-1:0]   r_data;
  logic                   r_last;
  logic                   r_done;
  logic                   r_timeout;
  logic [ADDR_BITW:0]     r_segCount;

  state_t                 w_stateNext;
  logic [TIMER_BITW-1:0]  w_timerNext;
  logic [ADDR_BITW:0]     w_lineNumNext;
  logic [ADDR_BITW-1:0]   w_rdAddrNext;
  logic [ADDR_BITW:0]     w_cntNext;
  logic                   w_protectNext;
  logic                   w_validNext;
  logic [WORD_SIZE-1:0]   w_dataNext;
  logic                   w_lastNext;
  logic                   w_doneNext;
  logic                   w_timeoutNext;
  logic [ADDR_BITW:0]     w_segCountNext;
  logic [ADDR_BITW-1:0]   w_lastAddr;

  // Index of the final word; for a full buffer the low bits are zero and this wraps to RAM_SIZE-1.
  assign w_lastAddr = r_lineNum[ADDR_BITW-1:0] - 1'b1;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_lineNum  <= '0;
      r_rdAddr   <= '0;
      r_cnt      <= '0;
      r_protect  <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_segCount <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_timer    <= w_timerNext;
      r_lineNum  <= w_lineNumNext;
      r_rdAddr   <= w_rdAddrNext;
      r_cnt      <= w_cntNext;
      r_protect  <= w_protectNext;
      r_valid    <= w_validNext;
      r_data     <= w_dataNext;
      r_last     <= w_lastNext;
      r_done     <= w_doneNext;
      r_timeout  <= w_timeoutNext;
      r_segCount <= w_segCountNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_timerNext    = r_timer;
    w_lineNumNext  = r_lineNum;
    w_rdAddrNext   = r_rdAddr;
    w_cntNext      = r_cnt;
    w_protectNext  = r_protect;
    w_validNext    = r_valid;
    w_dataNext     = r_data;
    w_lastNext     = r_last;
    w_doneNext     = 1'b0;
    w_timeoutNext  = 1'b0;
    w_segCountNext = r_segCount;

    case (r_state)
      IDLE: begin
        if (in_start) begin
          w_stateNext   = PROTECT;
          w_protectNext = 1'b1;
          w_timerNext   = '0;
          w_cntNext     = '0;
        end
      end
      PROTECT: begin
        if (in_buf_ready) begin
          w_lineNumNext = in_buf_line_num;
          w_rdAddrNext  = '0;
          w_cntNext     = '0;
          w_stateNext   = (in_buf_line_num == '0) ? RELEASE : LOAD;
        end else if (r_timer == TIMER_LAST) begin
          w_timeoutNext = 1'b1;
          w_stateNext   = RELEASE;
        end else begin
          w_timerNext = r_timer + 1'b1;
        end
      end
      LOAD: begin
        w_dataNext   = in_buf_data;
        w_validNext  = 1'b1;
        w_lastNext   = (r_lineNum == ONE_WORD);
        w_rdAddrNext = r_rdAddr + 1'b1;
        w_stateNext  = STREAM;
      end
      STREAM: begin
        // The buffer already presents the word at r_rdAddr, so the next word loads on the accepting edge.
        if (r_valid && in_ready) begin
          w_cntNext = r_cnt + 1'b1;
          if (r_last) begin
            w_validNext = 1'b0;
            w_lastNext  = 1'b0;
            w_stateNext = RELEASE;
          end else begin
            w_dataNext   = in_buf_data;
            w_rdAddrNext = r_rdAddr + 1'b1;
            w_lastNext   = (r_rdAddr == w_lastAddr);
          end
        end
      end
      RELEASE: begin
        // The buffer drops its grant only during blanking, so this wait is deliberately unbounded.
        w_protectNext = 1'b0;
        if (!in_buf_ready) begin
          w_segCountNext = r_cnt;
          w_doneNext     = 1'b1;
          w_stateNext    = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign out_write_protect = r_protect;
  assign out_rd_addr       = r_rdAddr;
  assign out_valid         = r_valid;
  assign out_data          = r_data;
  assign out_last          = r_last;
  assign out_busy          = (r_state != IDLE);
  assign out_done          = r_done;
  assign out_timeout       = r_timeout;
  assign out_seg_count     = r_segCount;

endmodule

// File: tb/tb_lsd_readout_ctrl.sv
// Directed bench for lsd_readout_ctrl with a small behavioural buffer whose read data
// is a fixed function of the read address.
module tb_lsd_readout_ctrl;

  localparam int FRAME_HEIGHT = 16;
  localparam int FRAME_WIDTH  = 16;
  localparam int RAM_SIZE     = 16;
  localparam int TIMEOUT_CYC  = 16;

  logic        clock;
  logic        n_rst;
  logic        in_start;
  logic        in_buf_ready;
  logic [4:0]  in_buf_line_num;
  logic [15:0] in_buf_data;
  logic        out_write_protect;
  logic [3:0]  out_rd_addr;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        in_ready;
  logic        out_busy;
  logic        out_done;
  logic        out_timeout;
  logic [4:0]  out_seg_count;

  int checks   = 0;
  int failures = 0;

  lsd_readout_ctrl #(
    .FRAME_HEIGHT(FRAME_HEIGHT),
    .FRAME_WIDTH (FRAME_WIDTH),
    .RAM_SIZE    (RAM_SIZE),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clock            (clock),
    .n_rst            (n_rst),
    .in_start         (in_start),
    .in_buf_ready     (in_buf_ready),
    .in_buf_line_num  (in_buf_line_num),
    .in_buf_data      (in_buf_data),
    .out_write_protect(out_write_protect),
    .out_rd_addr      (out_rd_addr),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_last         (out_last),
    .in_ready         (in_ready),
    .out_busy         (out_busy),
    .out_done         (out_done),
    .out_timeout      (out_timeout),
    .out_seg_count    (out_seg_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Distinct, address-dependent buffer contents so ordering errors show up.
  function automatic logic [15:0] bufWord(input logic [3:0] a);
    return {a, ~a, a + 4'd3, a ^ 4'h5};
  endfunction

  assign in_buf_data = bufWord(out_rd_addr);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic bufReady, input logic [4:0] lineNum,
                               input logic ready);
    in_start        = start;
    in_buf_ready    = bufReady;
    in_buf_line_num = lineNum;
    in_ready        = ready;
    tick();
  endtask

  // Drives in_ready (always high, or high every third cycle) and checks every presented word.
  task automatic streamWords(input int n, input bit stall, input bit pokeStart, input int expCycles);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 4 * n + 8) begin
      in_ready = stall ? (cyc % 3 == 0) : 1'b1;
      in_start = pokeStart && (cyc == 1);
      checkOutput("stream_valid", 32'(out_valid), 32'd1);
      checkOutput("stream_data", 32'(out_data), 32'(bufWord(4'(idx))));
      checkOutput("stream_last", 32'(out_last), 32'(idx == n - 1));
      checkOutput("stream_addr", 32'(out_rd_addr), 32'((idx + 1) % RAM_SIZE));
      if (out_valid && in_ready) idx++;
      tick();
      cyc++;
    end
    in_start = 1'b0;
    in_ready = 1'b0;
    checkOutput("stream_count", 32'(idx), 32'(n));
    checkOutput("stream_cycles", 32'(cyc), 32'(expCycles));
  endtask

  task automatic runReadout(input int n, input bit stall, input bit pokeStart, input int expCycles);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("start_protect", 32'(out_write_protect), 32'd1);
    checkOutput("start_busy", 32'(out_busy), 32'd1);
    checkOutput("start_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 5'(n), 1'b0);
    checkOutput("grant_valid", 32'(out_valid), 32'd0);
    if (n > 0) begin
      applyStimulus(1'b0, 1'b1, 5'd7, 1'b0);
      streamWords(n, stall, pokeStart, expCycles);
    end
    checkOutput("post_valid", 32'(out_valid), 32'd0);
    checkOutput("post_last", 32'(out_last), 32'd0);
    applyStimulus(1'b0, 1'b1, 5'd7, 1'b0);
    checkOutput("release_protect", 32'(out_write_protect), 32'd0);
    checkOutput("release_done", 32'(out_done), 32'd0);
    checkOutput("release_busy", 32'(out_busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd7, 1'b0);
    checkOutput("done_pulse", 32'(out_done), 32'd1);
    checkOutput("done_count", 32'(out_seg_count), 32'(n));
    checkOutput("done_busy", 32'(out_busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("idle_done", 32'(out_done), 32'd0);
    checkOutput("idle_busy", 32'(out_busy), 32'd0);
    checkOutput("idle_protect", 32'(out_write_protect), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_rst           = 1'b0;
    in_start        = 1'b0;
    in_buf_ready    = 1'b0;
    in_buf_line_num = '0;
    in_ready        = 1'b0;
    #3;
    checkOutput("rst_protect", 32'(out_write_protect), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(out_busy), 32'd0);
    checkOutput("rst_addr", 32'(out_rd_addr), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_count", 32'(out_seg_count), 32'd0);
    checkOutput("rst_flags", 32'({out_last, out_done, out_timeout}), 32'd0);
    tick();
    tick();
    n_rst = 1'b1;
    tick();

    $display("[TB] three-word readout, sink always ready");
    runReadout(3, 1'b0, 1'b0, 3);

    $display("[TB] protect grant timeout");
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    for (int k = 1; k < TIMEOUT_CYC; k++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
      checkOutput("timeout_early", 32'(out_timeout), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("timeout_pulse", 32'(out_timeout), 32'd1);
    checkOutput("timeout_done", 32'(out_done), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("timeout_clear", 32'(out_timeout), 32'd0);
    checkOutput("timeout_rel_done", 32'(out_done), 32'd1);
    checkOutput("timeout_protect", 32'(out_write_protect), 32'd0);
    checkOutput("timeout_count", 32'(out_seg_count), 32'd0);
    checkOutput("timeout_busy", 32'(out_busy), 32'd0);

    $display("[TB] four words with stalls and a start request while busy");
    runReadout(4, 1'b1, 1'b1, 10);

    $display("[TB] empty buffer");
    runReadout(0, 1'b0, 1'b0, 0);

    $display("[TB] full buffer");
    runReadout(RAM_SIZE, 1'b0, 1'b0, RAM_SIZE);

    $display("[TB] reset during streaming");
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd5, 1'b0);
    applyStimulus(1'b0, 1'b1, 5'd5, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd5, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd5, 1'b1);
    checkOutput("mid_valid", 32'(out_valid), 32'd1);
    checkOutput("mid_data", 32'(out_data), 32'(bufWord(4'd2)));
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("mrst_valid", 32'(out_valid), 32'd0);
    checkOutput("mrst_protect", 32'(out_write_protect), 32'd0);
    checkOutput("mrst_busy", 32'(out_busy), 32'd0);
    checkOutput("mrst_addr", 32'(out_rd_addr), 32'd0);
    checkOutput("mrst_data", 32'(out_data), 32'd0);
    checkOutput("mrst_flags", 32'({out_last, out_done, out_timeout}), 32'd0);
    in_buf_ready = 1'b0;
    in_ready     = 1'b0;
    #1;
    n_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("after_rst_busy", 32'(out_busy), 32'd0);
    checkOutput("after_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("after_rst_count", 32'(out_seg_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
